// File: rtl/bit_seq_pkg.sv
// Shared encodings for the serial bit-sequence generator and detector.
// State numbering is fixed so benches on both sides can decode it.
package bit_seq_pkg;

   localparam int STATE_W = 2;
   localparam int PAIR_W  = 8;
   localparam logic [PAIR_W-1:0] PAIR_MAX = 8'd255;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [PAIR_W-1:0] sat_inc(
      input logic [PAIR_W-1:0] v
   );
      return (v == PAIR_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/bit_seq_piso.sv
// Parallel-in/serial-out frame register with bit down-counter.
// Keeps a copy of the loaded word so repeated frames can be reloaded.
module bit_seq_piso #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic                         reload,
   input  logic                         shift,
   input  logic [WIDTH-1:0]             data,
   input  logic [$clog2(WIDTH+1)-1:0]   len,
   output logic                         msb,
   output logic                         last
);

   localparam int LW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] word;
   logic [LW-1:0]    wlen;
   logic [WIDTH-1:0] sr;
   logic [LW-1:0]    cnt;

   // Left-justify the frame so the next bit is always sr[WIDTH-1].
   function automatic logic [WIDTH-1:0] align(
      input logic [WIDTH-1:0] d,
      input logic [LW-1:0]    l
   );
      return d << (LW'(WIDTH) - l);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         word <= '0;
         wlen <= '0;
         sr   <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= data;
         wlen <= len;
         sr   <= align(data, len);
         cnt  <= len;
      end else if (reload) begin
         sr   <= align(word, wlen);
         cnt  <= wlen;
      end else if (shift) begin
         sr   <= sr << 1;
         cnt  <= cnt - LW'(1);
      end
   end

   assign msb  = sr[WIDTH-1];
   assign last = (cnt == LW'(1));

endmodule

// File: rtl/bit_seq_gen.sv
// Serial pattern transmitter: MSB-first frames, optional repeats with
// idle gaps, and a saturating count of adjacent "11" pairs per frame.
module bit_seq_gen
   import bit_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int GAP   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [WIDTH-1:0]             data,
   input  logic [$clog2(WIDTH+1)-1:0]   len,
   input  logic [CNT_W-1:0]             reps,
   output logic                         out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         done,
   output logic [PAIR_W-1:0]            pair_cnt
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t           state;
   state_t           next;
   logic [CNT_W-1:0] rep;
   logic [GW-1:0]    gcnt;
   logic             prev;
   logic             load;
   logic             reload;
   logic             shift;
   logic             msb;
   logic             last;

   bit_seq_piso #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .reload (reload),
      .shift  (shift),
      .data   (data),
      .len    (len),
      .msb    (msb),
      .last   (last)
   );

   always_comb begin
      next   = state;
      load   = 1'b0;
      reload = 1'b0;
      shift  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               load = 1'b1;
               next = (len != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            shift = 1'b1;
            if (last) begin
               if (rep != '0) begin
                  if (GAP == 0) begin
                     reload = 1'b1;
                     next   = ST_SHIFT;
                  end else begin
                     next   = ST_GAP;
                  end
               end else begin
                  next = ST_DONE;
               end
            end
         end
         ST_GAP: begin
            if (gcnt == '0) begin
               reload = 1'b1;
               next   = ST_SHIFT;
            end
         end
         ST_DONE: begin
            next = ST_IDLE;
         end
         default: next = ST_IDLE;
      endcase
   end

   // prev never survives a frame's last bit, so frames cannot chain pairs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         rep      <= '0;
         gcnt     <= '0;
         prev     <= 1'b0;
         pair_cnt <= '0;
      end else begin
         state <= next;
         if (load) begin
            rep      <= reps;
            prev     <= 1'b0;
            pair_cnt <= '0;
         end
         if (shift) begin
            prev <= msb & ~last;
            if (msb && prev)
               pair_cnt <= sat_inc(pair_cnt);
         end
         if (state == ST_SHIFT && last && rep != '0) begin
            rep  <= rep - CNT_W'(1);
            gcnt <= GW'(GAP - 1);
         end
         if (state == ST_GAP && gcnt != '0)
            gcnt <= gcnt - GW'(1);
      end
   end

   assign out       = (state == ST_SHIFT) & msb;
   assign out_valid = (state == ST_SHIFT);
   assign busy      = (state == ST_SHIFT) | (state == ST_GAP);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_bit_seq_gen.sv
// Directed bench for bit_seq_gen: two instances, one with a 2-cycle gap
// and 4-bit repeat count, one gapless with a 6-bit repeat count.
module tb_bit_seq_gen;
   import bit_seq_pkg::*;

   logic       clk;
   logic       reset;

   logic       a_start;
   logic [7:0] a_data;
   logic [3:0] a_len;
   logic [3:0] a_reps;
   logic       a_out;
   logic       a_out_valid;
   logic       a_busy;
   logic       a_done;
   logic [7:0] a_pair_cnt;

   logic       b_start;
   logic [7:0] b_data;
   logic [3:0] b_len;
   logic [5:0] b_reps;
   logic       b_out;
   logic       b_out_valid;
   logic       b_busy;
   logic       b_done;
   logic [7:0] b_pair_cnt;

   int checks;
   int failures;

   int           cap_first_done;
   int           cap_ndone;
   int           cap_nvalid;
   int           cap_nbusy;
   logic [511:0] cap_vpat;
   logic [511:0] cap_bits;
   logic [7:0]   cap_pair;
   logic [7:0]   cap_pair_last;

   bit_seq_gen #(
      .WIDTH (8),
      .CNT_W (4),
      .GAP   (2)
   ) u_a (
      .clk       (clk),
      .reset     (reset),
      .start     (a_start),
      .data      (a_data),
      .len       (a_len),
      .reps      (a_reps),
      .out       (a_out),
      .out_valid (a_out_valid),
      .busy      (a_busy),
      .done      (a_done),
      .pair_cnt  (a_pair_cnt)
   );

   bit_seq_gen #(
      .WIDTH (8),
      .CNT_W (6),
      .GAP   (0)
   ) u_b (
      .clk       (clk),
      .reset     (reset),
      .start     (b_start),
      .data      (b_data),
      .len       (b_len),
      .reps      (b_reps),
      .out       (b_out),
      .out_valid (b_out_valid),
      .busy      (b_busy),
      .done      (b_done),
      .pair_cnt  (b_pair_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input bit sel, input int ncyc, input int poke);
      logic       v;
      logic       o;
      logic       b;
      logic       d;
      logic [7:0] p;
      cap_first_done = -1;
      cap_ndone      = 0;
      cap_nvalid     = 0;
      cap_nbusy      = 0;
      cap_vpat       = '0;
      cap_bits       = '0;
      cap_pair       = '0;
      cap_pair_last  = '0;
      for (int c = 0; c < ncyc; c++) begin
         v = sel ? b_out_valid : a_out_valid;
         o = sel ? b_out : a_out;
         b = sel ? b_busy : a_busy;
         d = sel ? b_done : a_done;
         p = sel ? b_pair_cnt : a_pair_cnt;
         cap_vpat = {cap_vpat[510:0], v};
         if (v) begin
            cap_nvalid++;
            cap_bits = {cap_bits[510:0], o};
         end
         if (b) cap_nbusy++;
         if (d) begin
            cap_ndone++;
            if (cap_first_done < 0) begin
               cap_first_done = c;
               cap_pair = p;
            end
         end
         cap_pair_last = p;
         if (poke >= 0 && c == poke) begin
            a_start = 1'b1;
            a_data  = 8'hFF;
            a_len   = 4'd4;
            a_reps  = 4'd3;
         end else if (poke >= 0 && c == poke + 1) begin
            a_start = 1'b0;
         end
         tick();
      end
   endtask

   task automatic go_a(input logic [7:0] d, input logic [3:0] l,
                       input logic [3:0] r);
      a_data  = d;
      a_len   = l;
      a_reps  = r;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic go_b(input logic [7:0] d, input logic [3:0] l,
                       input logic [5:0] r);
      b_data  = d;
      b_len   = l;
      b_reps  = r;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_out, a_out_valid, a_busy, a_done} !== 4'b0) begin
         failures++;
         $display("FAIL reset_a_flags got=%b exp=0000",
                  {a_out, a_out_valid, a_busy, a_done});
      end
      checks++;
      if (a_pair_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_a_pair got=%0d exp=0", a_pair_cnt);
      end
      checks++;
      if ({b_out, b_out_valid, b_busy, b_done} !== 4'b0 ||
          b_pair_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_b got=%b/%0d exp=0000/0",
                  {b_out, b_out_valid, b_busy, b_done}, b_pair_cnt);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      go_a(8'b1011_0110, 4'd8, 4'd0);
      capture(1'b0, 10, -1);
      checks++;
      if (cap_bits[7:0] !== 8'b1011_0110 || cap_nvalid !== 8) begin
         failures++;
         $display("FAIL single_bits got=%b n=%0d exp=10110110 n=8",
                  cap_bits[7:0], cap_nvalid);
      end
      checks++;
      if (cap_first_done !== 8 || cap_ndone !== 1) begin
         failures++;
         $display("FAIL single_done got=%0d/%0d exp=8/1",
                  cap_first_done, cap_ndone);
      end
      checks++;
      if (cap_nbusy !== 8) begin
         failures++;
         $display("FAIL single_busy got=%0d exp=8", cap_nbusy);
      end
      checks++;
      if (cap_pair !== 8'd2) begin
         failures++;
         $display("FAIL single_pair got=%0d exp=2", cap_pair);
      end
   endtask

   task automatic test_repeat_gap();
      go_a(8'b0000_0111, 4'd3, 4'd2);
      capture(1'b0, 15, -1);
      checks++;
      if (cap_vpat[14:0] !== 15'b111001110011100) begin
         failures++;
         $display("FAIL repeat_vpat got=%b exp=111001110011100",
                  cap_vpat[14:0]);
      end
      checks++;
      if (cap_nbusy !== 13 || cap_first_done !== 13) begin
         failures++;
         $display("FAIL repeat_busy got=%0d/%0d exp=13/13",
                  cap_nbusy, cap_first_done);
      end
      checks++;
      if (cap_pair !== 8'd6) begin
         failures++;
         $display("FAIL repeat_pair got=%0d exp=6", cap_pair);
      end
   endtask

   task automatic test_zero_len();
      go_a(8'hFF, 4'd0, 4'd5);
      capture(1'b0, 3, -1);
      checks++;
      if (cap_first_done !== 0 || cap_ndone !== 1) begin
         failures++;
         $display("FAIL zero_done got=%0d/%0d exp=0/1",
                  cap_first_done, cap_ndone);
      end
      checks++;
      if (cap_nvalid !== 0 || cap_nbusy !== 0) begin
         failures++;
         $display("FAIL zero_valid got=%0d/%0d exp=0/0",
                  cap_nvalid, cap_nbusy);
      end
      checks++;
      if (cap_pair !== 8'd0) begin
         failures++;
         $display("FAIL zero_pair got=%0d exp=0", cap_pair);
      end
   endtask

   task automatic test_start_busy();
      go_a(8'b1100_1010, 4'd8, 4'd0);
      capture(1'b0, 14, 3);
      checks++;
      if (cap_bits[7:0] !== 8'b1100_1010 || cap_nvalid !== 8) begin
         failures++;
         $display("FAIL busy_bits got=%b n=%0d exp=11001010 n=8",
                  cap_bits[7:0], cap_nvalid);
      end
      checks++;
      if (cap_ndone !== 1 || cap_first_done !== 8) begin
         failures++;
         $display("FAIL busy_done got=%0d@%0d exp=1@8",
                  cap_ndone, cap_first_done);
      end
      checks++;
      if (cap_pair !== 8'd1) begin
         failures++;
         $display("FAIL busy_pair got=%0d exp=1", cap_pair);
      end
   endtask

   task automatic test_reset_mid();
      go_a(8'b1110_0101, 4'd8, 4'd0);
      tick();
      tick();
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out !== 1'b0 ||
          a_pair_cnt !== 8'd2) begin
         failures++;
         $display("FAIL mid_pre got=%b%b/%0d exp=10/2",
                  a_out_valid, a_out, a_pair_cnt);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({a_out, a_out_valid, a_busy, a_done} !== 4'b0 ||
          a_pair_cnt !== 8'd0) begin
         failures++;
         $display("FAIL mid_reset got=%b/%0d exp=0000/0",
                  {a_out, a_out_valid, a_busy, a_done}, a_pair_cnt);
      end
      checks++;
      if (u_a.state !== ST_IDLE) begin
         failures++;
         $display("FAIL mid_state got=%0d exp=0", u_a.state);
      end
      tick();
      go_a(8'b0110_1101, 4'd8, 4'd0);
      capture(1'b0, 10, -1);
      checks++;
      if (cap_bits[7:0] !== 8'b0110_1101 || cap_first_done !== 8) begin
         failures++;
         $display("FAIL mid_restart got=%b@%0d exp=01101101@8",
                  cap_bits[7:0], cap_first_done);
      end
      checks++;
      if (cap_pair !== 8'd2) begin
         failures++;
         $display("FAIL mid_pair got=%0d exp=2", cap_pair);
      end
   endtask

   task automatic test_back_to_back();
      a_data  = 8'b0000_0011;
      a_len   = 4'd2;
      a_reps  = 4'd0;
      a_start = 1'b1;
      tick();
      capture(1'b0, 12, -1);
      a_start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (cap_vpat[11:0] !== 12'b1100_1100_1100 || cap_ndone !== 3) begin
         failures++;
         $display("FAIL b2b_pattern got=%b/%0d exp=110011001100/3",
                  cap_vpat[11:0], cap_ndone);
      end
      checks++;
      if (cap_first_done !== 2 || cap_pair !== 8'd1) begin
         failures++;
         $display("FAIL b2b_first got=%0d/%0d exp=2/1",
                  cap_first_done, cap_pair);
      end
   endtask

   task automatic test_saturation();
      go_b(8'hFF, 4'd8, 6'd15);
      capture(1'b1, 132, -1);
      checks++;
      if (cap_nvalid !== 128 || cap_nbusy !== 128 ||
          cap_first_done !== 128) begin
         failures++;
         $display("FAIL sat15_len got=%0d/%0d/%0d exp=128/128/128",
                  cap_nvalid, cap_nbusy, cap_first_done);
      end
      checks++;
      if (cap_pair !== 8'd112 || cap_pair_last !== 8'd112) begin
         failures++;
         $display("FAIL sat15_pair got=%0d/%0d exp=112/112",
                  cap_pair, cap_pair_last);
      end
      go_b(8'hFF, 4'd8, 6'd40);
      capture(1'b1, 332, -1);
      checks++;
      if (cap_nvalid !== 328 || cap_first_done !== 328) begin
         failures++;
         $display("FAIL sat40_len got=%0d/%0d exp=328/328",
                  cap_nvalid, cap_first_done);
      end
      checks++;
      if (cap_pair !== 8'd255 || cap_pair_last !== 8'd255) begin
         failures++;
         $display("FAIL sat40_pair got=%0d/%0d exp=255/255",
                  cap_pair, cap_pair_last);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      a_start  = 1'b0;
      a_data   = '0;
      a_len    = '0;
      a_reps   = '0;
      b_start  = 1'b0;
      b_data   = '0;
      b_len    = '0;
      b_reps   = '0;
      test_reset();
      test_single();
      test_repeat_gap();
      test_zero_len();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bit_seq_gen.md
# bit_seq_gen

Serial bit-pattern transmitter: loads a parallel word, shifts it out MSB-first on a single-bit line, optionally repeats the frame with idle gaps, and counts the adjacent "11" pairs it emits. It is the transmit side of the serial sequence-detector path. It drives the detector's `in` line, and its `pair_cnt` is the golden count the detector's `out` pulses are checked against.

## Interface
Parameters:
- `WIDTH`, 8, maximum frame length in bits
- `CNT_W`, 4, width of the repeat count
- `GAP`, 2, idle cycles between repeated frames (0 allowed)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a transaction; sampled only in IDLE
- `data`  in  WIDTH  pattern; bits `data[len-1:0]` are sent
- `len`  in  $clog2(WIDTH+1)  frame length in bits, 0..WIDTH
- `reps`  in  CNT_W  extra repetitions; the block sends `reps+1` frames
- `out`  out  1  serial bit, registered
- `out_valid`  out  1  `out` carries a pattern bit this cycle
- `busy`  out  1  a transaction is in progress
- `done`  out  1  one-cycle pulse at the end of a transaction
- `pair_cnt`  out  8  "11" pairs emitted in the current or last transaction; saturates at 255

## Operation
- Moore FSM with states IDLE, SHIFT, GAP and DONE. All outputs are registered and are a function of state and datapath registers.
- **IDLE:** `busy`=0. When `start`=1:
  - latch `data`, `len` and `reps`
  - clear `pair_cnt`
  - go to SHIFT if `len`≠0, otherwise go to DONE.
- **SHIFT:**
  - `out` = current bit, starting at `data[len-1]` and ending at `data[0]`; `out_valid`=1.
  - A bit counter runs from `len` down to 1.
  - After the last bit, if the repeat counter is greater than 0: decrement it, then go to GAP, or straight back to SHIFT when `GAP`=0.
  - After the last bit with the repeat counter at 0: go to DONE.
- **GAP:**
  - `out`=0, `out_valid`=0 for exactly `GAP` cycles.
  - Then reload the shift register from the latched word and return to SHIFT.
- **DONE:** `done`=1 for one cycle, `busy`=0, `out_valid`=0. Next state is IDLE.
- `busy`=1 in SHIFT and GAP only.
- **`start` while not in IDLE:** ignored. This includes `start` held high through DONE; a new transaction can begin on the first IDLE cycle.
- **Inputs after latch:** changes to `data`, `len` or `reps` after the latch have no effect on the transaction.
- **Pair counting:**
  - `pair_cnt` increments when a valid bit is 1 and the previous valid bit in the same frame was 1.
  - Frames do not chain. The first bit of every frame has no predecessor, whether or not a gap precedes it.
  - Saturates at 255, with no wrap.
  - Holds its value after DONE until the next accepted `start`.
- **Reset:** at the first edge with `reset`=1, from any state, including mid-frame, the block goes to IDLE. All outputs become 0 (`out`, `out_valid`, `busy`, `done` and `pair_cnt`), and the latched word and counters clear.

## Timing
- **First bit:** `start` is sampled at edge k. The first bit appears on `out` with `out_valid`=1 in the cycle after edge k.
- **Transaction length:** `out_valid` is high for `len` consecutive cycles per frame. A transaction occupies (`reps`+1)·`len` + `reps`·`GAP` busy cycles, followed by one DONE cycle.
- **`len`=0:** DONE occurs in the cycle after edge k, with no valid bits and `pair_cnt`=0.
- **Back-to-back transactions:** the minimum spacing between two accepted starts is the busy cycles plus 2 (DONE, then IDLE).
- **`GAP`=0:** frames are contiguous. The pair counter still restarts its predecessor tracking at each frame boundary.

## Structure
- **Shared package `bit_seq_pkg`:** holds the state encoding (IDLE=0, SHIFT=1, GAP=2, DONE=3), the state width, and the `pair_cnt` width and saturation value. The matching detector and its benches use the same package.
- **Sub-module `bit_seq_piso`:**
  - parallel-in/serial-out shift register with a load strobe, a shift enable and a down-counter
  - flags the last bit of a frame
  - the FSM, repeat counter, gap counter and pair counter stay in `bit_seq_gen`.

## Test plan
- **Single frame:** reset for 2 cycles, then `start` with `data`=8'b1011_0110, `len`=8, `reps`=0.
  - Required: `out` = 1,0,1,1,0,1,1,0 on 8 consecutive valid cycles, then `done` in the next cycle.
  - Required: `pair_cnt`=2, `busy` high for exactly 8 cycles.
- **Repeat with gap:** `data`=3'b111, `len`=3, `reps`=2, `GAP`=2.
  - Required: valid pattern 3 on, 2 off, 3 on, 2 off, 3 on, giving 13 busy cycles.
  - Required: `pair_cnt`=6 (no pair counted across frames).
- **Zero length:** `len`=0 with `reps`=5.
  - Required: `done` in the cycle after `start`, `out_valid` never asserted, `pair_cnt`=0.
- **Start during busy:** pulse `start` with new `data` during SHIFT.
  - Required: the transmitted stream is unchanged and exactly one `done` pulse occurs.
- **Reset mid-frame:** assert `reset` during bit 4 of an 8-bit frame.
  - Required: at the next edge all outputs are 0 and the state is IDLE.
  - Required: a following `start` transmits the new word correctly from its MSB.
- **Saturation:** `WIDTH`=8, `data`=8'hFF, `len`=8, `reps`=15, `GAP`=0.
  - Required: 128 valid cycles, 7 pairs per frame, `pair_cnt`=112.
  - Re-run with `CNT_W`=6 and `reps`=40: `pair_cnt`=255 held (saturated).
